// File: rtl/execute_stage.sv
// Execute stage: single-cycle ALU plus a 33-cycle shift-add multiplier.
// Registers the memory-access stage's inputs and stalls decode while a
// multiply is iterating. Downstream sees bubbles during the multiply.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    output logic        stall_o,
    input  logic [3:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [31:0] store_data_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic        write_to_reg_i,
    input  logic [4:0]  dst_reg_i,
    output logic [31:0] adr,
    output logic [31:0] store_data,
    output logic        enable_read,
    output logic        enable_write,
    output logic        write_to_reg,
    output logic [4:0]  dst_reg
);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_XOR   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_MUL   = 4'd10;
    localparam logic [3:0] OP_MULHU = 4'd11;
    localparam logic [3:0] OP_PASSB = 4'd12;

    typedef enum logic [0:0] {IDLE, MUL_BUSY} state_t;

    // Everything that travels with an instruction besides its result.
    typedef struct packed {
        logic [31:0] store_data;
        logic        rd;
        logic        wr;
        logic        wtr;
        logic [4:0]  dst;
    } ctl_t;

    state_t      state, state_n;
    logic [4:0]  count, count_n;
    logic [31:0] mcand, mcand_n;
    logic [63:0] prod, prod_n;
    logic        sel_hi, sel_hi_n;
    ctl_t        ctl_q, ctl_n;
    ctl_t        out_q, out_n;
    logic [31:0] adr_n;
    logic [31:0] alu_res;
    logic [32:0] mul_sum;
    logic [63:0] mul_step;
    logic        stall_raw;
    logic        is_mul;
    ctl_t        ctl_in;

    assign is_mul = (op_i == OP_MUL) || (op_i == OP_MULHU);
    assign ctl_in = '{store_data: store_data_i, rd: mem_read_i, wr: mem_write_i,
                      wtr: write_to_reg_i, dst: dst_reg_i};

    // Single-cycle ALU; reserved opcodes produce 0.
    always_comb begin
        alu_res = '0;
        case (op_i)
            OP_ADD:   alu_res = a_i + b_i;
            OP_SUB:   alu_res = a_i - b_i;
            OP_AND:   alu_res = a_i & b_i;
            OP_OR:    alu_res = a_i | b_i;
            OP_XOR:   alu_res = a_i ^ b_i;
            OP_SLL:   alu_res = a_i << b_i[4:0];
            OP_SRL:   alu_res = a_i >> b_i[4:0];
            OP_SRA:   alu_res = $unsigned($signed(a_i) >>> b_i[4:0]);
            OP_SLT:   alu_res = {31'd0, $signed(a_i) < $signed(b_i)};
            OP_SLTU:  alu_res = {31'd0, a_i < b_i};
            OP_PASSB: alu_res = b_i;
            default:  alu_res = '0;
        endcase
    end

    // One shift-add iteration: conditional add into the high half keeping
    // the carry, which then becomes bit 63 after the right shift.
    always_comb begin
        mul_sum  = prod[0] ? ({1'b0, prod[63:32]} + {1'b0, mcand}) : {1'b0, prod[63:32]};
        mul_step = {mul_sum, prod[31:1]};
    end

    // Next-state and next-output logic; default is a bubble with state held.
    always_comb begin
        state_n   = state;
        count_n   = count;
        mcand_n   = mcand;
        prod_n    = prod;
        sel_hi_n  = sel_hi;
        ctl_n     = ctl_q;
        adr_n     = '0;
        out_n     = '0;
        stall_raw = 1'b0;
        case (state)
            IDLE: begin
                if (valid_i) begin
                    if (is_mul) begin
                        stall_raw = 1'b1;
                        mcand_n   = a_i;
                        prod_n    = {32'd0, b_i};
                        sel_hi_n  = (op_i == OP_MULHU);
                        ctl_n     = ctl_in;
                        count_n   = '0;
                        state_n   = MUL_BUSY;
                    end else begin
                        adr_n = alu_res;
                        out_n = ctl_in;
                    end
                end
            end
            MUL_BUSY: begin
                prod_n  = mul_step;
                count_n = count + 5'd1;
                if (count == 5'd31) begin
                    adr_n   = sel_hi ? mul_step[63:32] : mul_step[31:0];
                    out_n   = ctl_q;
                    state_n = IDLE;
                end else begin
                    stall_raw = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Stall is suppressed while reset is asserted.
    assign stall_o = rst & stall_raw;

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= IDLE;
            count  <= '0;
            mcand  <= '0;
            prod   <= '0;
            sel_hi <= 1'b0;
            ctl_q  <= '0;
            out_q  <= '0;
            adr    <= '0;
        end else begin
            state  <= state_n;
            count  <= count_n;
            mcand  <= mcand_n;
            prod   <= prod_n;
            sel_hi <= sel_hi_n;
            ctl_q  <= ctl_n;
            out_q  <= out_n;
            adr    <= adr_n;
        end
    end

    assign store_data   = out_q.store_data;
    assign enable_read  = out_q.rd;
    assign enable_write = out_q.wr;
    assign write_to_reg = out_q.wtr;
    assign dst_reg      = out_q.dst;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: directed cases plus random ops
// compared against an arithmetic reference model.
module tb_execute_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        stall_o;
    logic [3:0]  op_i;
    logic [31:0] a_i, b_i, store_data_i;
    logic        mem_read_i, mem_write_i, write_to_reg_i;
    logic [4:0]  dst_reg_i;
    logic [31:0] adr, store_data;
    logic        enable_read, enable_write, write_to_reg;
    logic [4:0]  dst_reg;

    int total = 0;
    int bad   = 0;

    execute_stage dut (
        .clk(clk), .rst(rst), .valid_i(valid_i), .stall_o(stall_o), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .store_data_i(store_data_i), .mem_read_i(mem_read_i),
        .mem_write_i(mem_write_i), .write_to_reg_i(write_to_reg_i), .dst_reg_i(dst_reg_i),
        .adr(adr), .store_data(store_data), .enable_read(enable_read),
        .enable_write(enable_write), .write_to_reg(write_to_reg), .dst_reg(dst_reg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: result of an opcode straight from its definition.
    function automatic logic [31:0] model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned p;
        logic [31:0] r;
        p = longint'(a) * longint'(b);
        case (op)
            4'd0:  r = a + b;
            4'd1:  r = a - b;
            4'd2:  r = a & b;
            4'd3:  r = a | b;
            4'd4:  r = a ^ b;
            4'd5:  r = a << b[4:0];
            4'd6:  r = a >> b[4:0];
            4'd7:  r = $unsigned($signed(a) >>> b[4:0]);
            4'd8:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd9:  r = (a < b) ? 32'd1 : 32'd0;
            4'd10: r = p[31:0];
            4'd11: r = p[63:32];
            4'd12: r = b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] ctl_obs();
        return {24'd0, store_data, enable_read, enable_write, write_to_reg, dst_reg};
    endfunction

    task automatic drive(input logic v, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] sd, input logic mr, input logic mw, input logic wtr,
                         input logic [4:0] dst);
        valid_i = v; op_i = op; a_i = a; b_i = b; store_data_i = sd;
        mem_read_i = mr; mem_write_i = mw; write_to_reg_i = wtr; dst_reg_i = dst;
    endtask

    // Single-cycle op (or bubble when v=0): outputs one edge later.
    task automatic single(input string tag, input logic v, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] sd, input logic mr, input logic mw,
                          input logic wtr, input logic [4:0] dst);
        logic [31:0] ea;
        logic [63:0] ec;
        drive(v, op, a, b, sd, mr, mw, wtr, dst);
        ea = v ? model(op, a, b) : 32'd0;
        ec = v ? {24'd0, sd, mr, mw, wtr, dst} : 64'd0;
        @(negedge clk);
        chk({tag, "_stall"}, {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        chk({tag, "_adr"}, {32'd0, adr}, {32'd0, ea});
        chk({tag, "_ctl"}, ctl_obs(), ec);
    endtask

    // Multiply: counts stall cycles, expects a bubble after each, then result.
    task automatic mul_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] sd, input logic mr, input logic mw, input logic wtr,
                          input logic [4:0] dst);
        int stalls;
        bit done;
        stalls = 0;
        done   = 0;
        drive(1'b1, op, a, b, sd, mr, mw, wtr, dst);
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall_o) begin
                stalls++;
                @(posedge clk); #1;
                chk({tag, "_bubble"}, {adr, 32'd0} | ctl_obs(), 64'd0);
            end else begin
                @(posedge clk); #1;
                done = 1;
            end
        end
        chk({tag, "_stalls"}, 64'(stalls), 64'd32);
        chk({tag, "_adr"}, {32'd0, adr}, {32'd0, model(op, a, b)});
        chk({tag, "_ctl"}, ctl_obs(), {24'd0, sd, mr, mw, wtr, dst});
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra, rb;
        rst = 1'b0;
        drive(1'b1, 4'd0, 32'd1, 32'd2, 32'h55, 1'b0, 1'b0, 1'b1, 5'd3);

        // Reset held two cycles with a valid ADD presented.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk("rst_stall", {63'd0, stall_o}, 64'd0);
            @(posedge clk); #1;
            chk("rst_adr", {32'd0, adr}, 64'd0);
            chk("rst_ctl", ctl_obs(), 64'd0);
        end
        rst = 1'b1;
        single("first", 1'b1, 4'd0, 32'd1, 32'd2, 32'h55, 1'b0, 1'b0, 1'b1, 5'd3);

        // ALU boundary sweep.
        single("add_wrap", 1'b1, 4'd0, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1);
        single("sub",      1'b1, 4'd1, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1);
        single("slt",      1'b1, 4'd8, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1);
        single("sltu",     1'b1, 4'd9, 32'hFFFFFFFF, 32'd1, 32'd0, 1'b0, 1'b0, 1'b1, 5'd1);
        single("sra",      1'b1, 4'd7, 32'h80000000, 32'h21, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2);
        single("srl",      1'b1, 4'd6, 32'h80000000, 32'h21, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2);
        single("sll",      1'b1, 4'd5, 32'h80000000, 32'h21, 32'd0, 1'b0, 1'b0, 1'b1, 5'd2);
        single("resv",     1'b1, 4'd14, 32'h1234, 32'h5678, 32'hA5, 1'b1, 1'b0, 1'b1, 5'd9);
        single("store",    1'b1, 4'd0, 32'h10, 32'd4, 32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 5'd0);
        single("bubble",   1'b0, 4'd0, 32'h10, 32'd4, 32'h1, 1'b1, 1'b0, 1'b1, 5'd7);

        // Directed multiplies, back to back, including full-carry case.
        mul_op("mul",   4'd10, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        mul_op("mulhu", 4'd11, 32'hFFFFFFFF, 32'd2, 32'd0, 1'b0, 1'b0, 1'b1, 5'd5);
        mul_op("mulhu_max", 4'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 1'b0, 1'b1, 5'd6);

        // Reset in the middle of a multiply (count = 10).
        drive(1'b1, 4'd10, 32'd7, 32'd9, 32'd0, 1'b0, 1'b0, 1'b1, 5'd4);
        repeat (11) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mrst_stall", {63'd0, stall_o}, 64'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        valid_i = 1'b0;
        chk("mrst_adr", {32'd0, adr}, 64'd0);
        chk("mrst_ctl", ctl_obs(), 64'd0);
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            chk("mrst_idle_stall", {63'd0, stall_o}, 64'd0);
            @(posedge clk); #1;
            chk("mrst_nores", {32'd0, adr}, 64'd0);
        end
        single("post_add", 1'b1, 4'd0, 32'd3, 32'd4, 32'd0, 1'b0, 1'b0, 1'b1, 5'd8);

        // Random mix against the reference model.
        for (int i = 0; i < 80; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
            if (rop == 4'd10 || rop == 4'd11)
                mul_op("rnd_mul", rop, ra, rb, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
            else
                single("rnd", 1'($urandom_range(0, 3) != 0), rop, ra, rb, $urandom,
                       1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
